// File: rtl/ternary_sys_ctrl.sv
// rtl/ternary_sys_ctrl.sv - ternary core system controller: program loader, run control, perf counters
module ternary_sys_ctrl #(
    parameter int NUM_SLOTS   = 2,
    parameter int ADDR_W      = 8,
    parameter int INSN_BITS   = 18,
    parameter int IMEM_DEPTH  = 243,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_start,
    input  logic                 prog_valid,
    output logic                 prog_ready,
    input  logic [INSN_BITS-1:0] prog_data,
    input  logic                 prog_last,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_waddr,
    output logic [INSN_BITS-1:0] imem_wdata,
    output logic                 cpu_rst_n,
    input  logic                 cpu_halted,
    input  logic [NUM_SLOTS-1:0] cpu_valid,
    input  logic                 cpu_stall,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [1:0]           state_out,
    output logic                 error
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int PC_W = $clog2(NUM_SLOTS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  WDOG_LIMIT = CNT_W'(WDOG_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMEM_DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] load_addr;
    logic              beat;
    logic [PC_W-1:0]   retire_pop;
    logic [CNT_W-1:0]  cycle_next;
    logic [CNT_W-1:0]  retire_next;
    logic [CNT_W-1:0]  stall_next;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    always_comb begin
        retire_pop = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            retire_pop = retire_pop + PC_W'(cpu_valid[i]);
        end
    end

    assign cycle_next  = sat_add(cycle_cnt, CNT_W'(1));
    assign retire_next = sat_add(retire_cnt, CNT_W'(retire_pop));
    assign stall_next  = sat_add(stall_cnt, CNT_W'(cpu_stall));

    // Gating with rst keeps the core in reset and blocks writes even before the reset edge lands.
    assign prog_ready = (state == S_LOAD) && !rst;
    assign beat       = prog_valid && prog_ready;
    assign imem_we    = beat;
    assign imem_waddr = load_addr;
    assign imem_wdata = prog_data;
    assign cpu_rst_n  = state[1] && !rst;
    assign state_out  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            load_addr  <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (prog_start) begin
                        state     <= S_LOAD;
                        load_addr <= '0;
                        error     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        load_addr <= load_addr + 1'b1;
                        if (prog_last) begin
                            state      <= S_RUN;
                            cycle_cnt  <= '0;
                            retire_cnt <= '0;
                            stall_cnt  <= '0;
                        end else if (load_addr == LAST_ADDR) begin
                            state <= S_IDLE;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    cycle_cnt  <= cycle_next;
                    retire_cnt <= retire_next;
                    stall_cnt  <= stall_next;
                    // A halt on the watchdog's final cycle is a clean finish, not a fault.
                    if (cpu_halted) begin
                        state <= S_DONE;
                    end else if (WDOG_CYCLES != 0 && cycle_next == WDOG_LIMIT) begin
                        state <= S_DONE;
                        error <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ternary_sys_ctrl.sv
// tb/tb_ternary_sys_ctrl.sv - model-checked bench for ternary_sys_ctrl (two parameter sets)
module tb_ternary_sys_ctrl;
    localparam int CMAX = 255;

    logic        clk = 1'b0;
    logic        rst, prog_start, prog_valid, prog_last, cpu_halted, cpu_stall;
    logic [17:0] prog_data;
    logic [1:0]  cpu_valid;

    logic        ready_w [2];
    logic        we_w    [2];
    logic [7:0]  waddr_w [2];
    logic [17:0] wdata_w [2];
    logic        rstn_w  [2];
    logic [7:0]  cyc_w   [2];
    logic [7:0]  ret_w   [2];
    logic [7:0]  stl_w   [2];
    logic [1:0]  st_w    [2];
    logic        err_w   [2];

    int checks = 0;
    int failures = 0;

    int depth [2] = '{6, 4};
    int wdog  [2] = '{0, 5};
    int m_st [2], m_addr [2], m_cyc [2], m_ret [2], m_stl [2], m_err [2];
    bit mvalid = 0;

    always #5 clk = ~clk;

    ternary_sys_ctrl #(.NUM_SLOTS(2), .ADDR_W(8), .INSN_BITS(18), .IMEM_DEPTH(6),
                       .CNT_W(8), .WDOG_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .prog_start(prog_start), .prog_valid(prog_valid),
        .prog_ready(ready_w[0]), .prog_data(prog_data), .prog_last(prog_last),
        .imem_we(we_w[0]), .imem_waddr(waddr_w[0]), .imem_wdata(wdata_w[0]),
        .cpu_rst_n(rstn_w[0]), .cpu_halted(cpu_halted), .cpu_valid(cpu_valid),
        .cpu_stall(cpu_stall), .cycle_cnt(cyc_w[0]), .retire_cnt(ret_w[0]),
        .stall_cnt(stl_w[0]), .state_out(st_w[0]), .error(err_w[0]));

    ternary_sys_ctrl #(.NUM_SLOTS(2), .ADDR_W(8), .INSN_BITS(18), .IMEM_DEPTH(4),
                       .CNT_W(8), .WDOG_CYCLES(5)) dut_b (
        .clk(clk), .rst(rst), .prog_start(prog_start), .prog_valid(prog_valid),
        .prog_ready(ready_w[1]), .prog_data(prog_data), .prog_last(prog_last),
        .imem_we(we_w[1]), .imem_waddr(waddr_w[1]), .imem_wdata(wdata_w[1]),
        .cpu_rst_n(rstn_w[1]), .cpu_halted(cpu_halted), .cpu_valid(cpu_valid),
        .cpu_stall(cpu_stall), .cycle_cnt(cyc_w[1]), .retire_cnt(ret_w[1]),
        .stall_cnt(stl_w[1]), .state_out(st_w[1]), .error(err_w[1]));

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] got=%0h expected=%0h", name, k, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Model: 0 idle, 1 loading, 2 running, 3 done.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k] = 0; m_addr[k] = 0; m_err[k] = 0;
                m_cyc[k] = 0; m_ret[k] = 0; m_stl[k] = 0;
            end else if (m_st[k] == 0 || m_st[k] == 3) begin
                if (prog_start) begin
                    m_st[k] = 1; m_addr[k] = 0; m_err[k] = 0;
                end
            end else if (m_st[k] == 1) begin
                if (prog_valid) begin
                    if (prog_last) begin
                        m_st[k] = 2; m_cyc[k] = 0; m_ret[k] = 0; m_stl[k] = 0;
                    end else if (m_addr[k] == depth[k] - 1) begin
                        m_st[k] = 0; m_err[k] = 1;
                    end
                    m_addr[k] = m_addr[k] + 1;
                end
            end else begin
                m_cyc[k] = sat(m_cyc[k] + 1);
                m_ret[k] = sat(m_ret[k] + $countones(cpu_valid));
                m_stl[k] = sat(m_stl[k] + int'(cpu_stall));
                if (cpu_halted) m_st[k] = 3;
                else if (wdog[k] != 0 && m_cyc[k] == wdog[k]) begin
                    m_st[k] = 3; m_err[k] = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                bit e_ready, e_we;
                e_ready = !rst && m_st[k] == 1;
                e_we    = e_ready && prog_valid;
                chk("prog_ready", k, ready_w[k], e_ready);
                chk("imem_we", k, we_w[k], e_we);
                if (e_we) begin
                    chk("imem_waddr", k, waddr_w[k], m_addr[k]);
                    chk("imem_wdata", k, wdata_w[k], prog_data);
                end
                chk("cpu_rst_n", k, rstn_w[k], !rst && m_st[k] >= 2);
                chk("state_out", k, st_w[k], m_st[k]);
                chk("error", k, err_w[k], m_err[k]);
                chk("cycle_cnt", k, cyc_w[k], m_cyc[k]);
                chk("retire_cnt", k, ret_w[k], m_ret[k]);
                chk("stall_cnt", k, stl_w[k], m_stl[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        mvalid = 1;
        #1;
    endtask

    task automatic idle_inputs();
        prog_start = 0; prog_valid = 0; prog_last = 0; prog_data = '0;
        cpu_halted = 0; cpu_valid = '0; cpu_stall = 0;
    endtask

    task automatic load_one();
        prog_start = 1; tick(); prog_start = 0;
        prog_valid = 1; prog_last = 1; prog_data = 18'h2aaaa; tick();
        prog_valid = 0; prog_last = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        chk("reset_state", 0, st_w[0], 0);
        chk("reset_rstn", 0, rstn_w[0], 0);
        chk("reset_cyc", 1, cyc_w[1], 0);
        rst = 0;

        // 4-word load, valid every cycle
        prog_start = 1; tick(); prog_start = 0;
        for (int i = 0; i < 4; i++) begin
            prog_valid = 1; prog_data = 18'(i + 1); prog_last = (i == 3);
            #1;
            chk("load4_we", 0, we_w[0], 1);
            chk("load4_addr", 0, waddr_w[0], i);
            chk("load4_data", 0, wdata_w[0], i + 1);
            tick();
        end
        prog_valid = 0; prog_last = 0;
        chk("load4_run", 0, st_w[0], 2);
        chk("load4_rstn", 0, rstn_w[0], 1);

        // 10 run cycles with halt on the last
        for (int c = 0; c < 10; c++) begin
            cpu_valid = (c < 6) ? 2'b11 : 2'b01;
            cpu_stall = (c < 3);
            cpu_halted = (c == 9);
            tick();
        end
        idle_inputs();
        chk("run_cyc", 0, cyc_w[0], 10);
        chk("run_ret", 0, ret_w[0], 16);
        chk("run_stl", 0, stl_w[0], 3);
        chk("run_done", 0, st_w[0], 3);
        chk("wdog_done", 1, st_w[1], 3);
        chk("wdog_err", 1, err_w[1], 1);
        chk("wdog_cyc", 1, cyc_w[1], 5);

        // halt on the watchdog's final cycle
        load_one();
        for (int c = 0; c < 5; c++) begin
            cpu_halted = (c == 4); tick();
        end
        cpu_halted = 0;
        chk("wdog_halt_err", 1, err_w[1], 0);
        chk("wdog_halt_done", 1, st_w[1], 3);

        // toggled valid over a 3-word load
        prog_start = 1; tick(); prog_start = 0;
        for (int i = 0; i < 5; i++) begin
            prog_valid = (i % 2 == 0); prog_data = 18'(16 + i); prog_last = (i == 4);
            #1;
            chk("toggle_we", 0, we_w[0], prog_valid);
            if (prog_valid) chk("toggle_addr", 0, waddr_w[0], i / 2);
            tick();
        end
        prog_valid = 0; prog_last = 0;
        chk("toggle_run", 0, st_w[0], 2);

        // reset on the 2nd run cycle
        tick();
        rst = 1; #1;
        chk("rst_mid_rstn", 0, rstn_w[0], 0);
        tick(); rst = 0;
        chk("rst_mid_state", 0, st_w[0], 0);
        chk("rst_mid_cyc", 0, cyc_w[0], 0);
        chk("rst_mid_rstn2", 0, rstn_w[0], 0);

        // overflow of a 4-deep memory
        prog_start = 1; tick(); prog_start = 0;
        for (int i = 0; i < 4; i++) begin
            prog_valid = 1; prog_data = 18'(32 + i); tick();
        end
        prog_valid = 0;
        chk("ovf_err", 1, err_w[1], 1);
        chk("ovf_idle", 1, st_w[1], 0);
        prog_start = 1; tick(); prog_start = 0;
        chk("ovf_clear", 1, err_w[1], 0);
        rst = 1; tick(); rst = 0;

        // counter saturation
        load_one();
        for (int c = 0; c < 300; c++) begin
            cpu_valid = 2'($urandom_range(1, 3)); cpu_stall = 1; tick();
        end
        idle_inputs();
        chk("sat_cyc", 0, cyc_w[0], CMAX);
        chk("sat_ret", 0, ret_w[0], CMAX);
        chk("sat_stl", 0, stl_w[0], CMAX);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 127) == 0);
            prog_start = ($urandom_range(0, 7) == 0);
            prog_valid = $urandom_range(0, 1);
            prog_last  = ($urandom_range(0, 3) == 0);
            prog_data  = 18'($urandom);
            cpu_halted = ($urandom_range(0, 15) == 0);
            cpu_valid  = 2'($urandom);
            cpu_stall  = $urandom_range(0, 1);
            tick();
        end
        idle_inputs(); rst = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ternary_sys_ctrl.md
TERNARY_SYS_CTRL -- requirements
Module: ternary_sys_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 2, number of issue slots reported by the core.
REQ-002 SHALL have parameter ADDR_W, default 8, instruction-memory write address width.
REQ-003 SHALL have parameter INSN_BITS, default 18, bits per instruction word (9 trits x 2 bits).
REQ-004 SHALL have parameter IMEM_DEPTH, default 243, instruction words loadable.
REQ-005 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-006 SHALL have parameter WDOG_CYCLES, default 0, run-cycle watchdog limit (0 = disabled).
REQ-007 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_start  in  1  one-cycle request to begin a program load.
- prog_valid  in  1  load beat valid.
- prog_ready  out  1  load beat accepted when valid&ready.
- prog_data  in  INSN_BITS  instruction word.
- prog_last  in  1  marks the final beat.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  ADDR_W  write address.
- imem_wdata  out  INSN_BITS  write data.
- cpu_rst_n  out  1  active-low reset to the core.
- cpu_halted  in  1  core halted.
- cpu_valid  in  NUM_SLOTS  per-slot retire valid.
- cpu_stall  in  1  core pipeline stall.
- cycle_cnt, retire_cnt, stall_cnt  out  CNT_W each  performance counters.
- state_out  out  2  current state encoding.
- error  out  1  sticky fault flag.

Function
REQ-008 SHALL implement FSM IDLE(0), LOAD(1), RUN(2), DONE(3); state_out shows the state register.
REQ-009 IDLE: prog_ready=0, cpu_rst_n=0; prog_start -> LOAD next cycle, load address cleared to 0, error cleared.
REQ-010 LOAD: prog_ready=1, cpu_rst_n=0; accepted beat drives imem_we=1, imem_waddr=load address, imem_wdata=prog_data combinationally in the same cycle; address increments by 1.
REQ-011 LOAD: accepted beat with prog_last=1 -> RUN next cycle; all counters cleared on this transition.
REQ-012 LOAD: accepted beat at address IMEM_DEPTH-1 with prog_last=0 is written, then error=1 and -> IDLE.
REQ-013 imem_we SHALL be 0 whenever no beat is accepted; prog_valid outside LOAD ignored.
REQ-014 RUN: cpu_rst_n=1; each cycle cycle_cnt+=1, retire_cnt+=popcount(cpu_valid), stall_cnt+=cpu_stall; all counters saturate at 2^CNT_W-1.
REQ-015 RUN: cpu_halted=1 -> DONE next cycle; that cycle is still counted.
REQ-016 RUN: WDOG_CYCLES!=0 and updated cycle_cnt equals WDOG_CYCLES with cpu_halted=0 -> error=1, DONE; halt in same cycle wins (no error).
REQ-017 DONE: cpu_rst_n stays 1 (core register state preserved for debug reads); counters frozen; prog_start -> LOAD, error cleared, counters hold until next RUN entry.
REQ-018 prog_start in LOAD or RUN SHALL be ignored.

Reset
REQ-019 rst=1 at a clock edge SHALL set state IDLE, load address 0, all counters 0, error 0, regardless of state; during and after reset cpu_rst_n=0, prog_ready=0, imem_we=0.
REQ-020 rst mid-LOAD or mid-RUN SHALL abort with no further imem writes.

Verification
REQ-021 Load 4 words 0x00001..0x00004 (last on 4th), valid every cycle -> writes addr 0..3, RUN on cycle after 4th beat, cpu_rst_n rises.
REQ-022 prog_valid toggled 1/0 over 3-word load -> only accepted beats write, addresses contiguous 0..2.
REQ-023 RUN 10 cycles, cpu_valid=2'b11 x6, 2'b01 x4, cpu_stall=1 x3, halt on 10th -> cycle_cnt=10, retire_cnt=16, stall_cnt=3, DONE.
REQ-024 IMEM_DEPTH=4, 4 beats none last -> 4 writes, error=1, IDLE; next prog_start clears error.
REQ-025 WDOG_CYCLES=5, no halt -> DONE after 5 RUN cycles, error=1; halt on 5th -> error=0.
REQ-026 rst asserted at 2nd RUN cycle -> IDLE, counters 0, cpu_rst_n=0 next cycle.
